// File: rtl/eth_pkt_gen_pkg.sv
// Shared types and constants for the Ethernet packet-traffic sequencer.
package eth_pkt_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE,
        ST_GAP,
        ST_FINISH
    } gen_state_e;

    localparam int unsigned PATTERN_INC  = 0;
    localparam int unsigned PATTERN_LFSR = 1;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/eth_pkt_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load and single-step advance.
module eth_pkt_gen_lfsr
    import eth_pkt_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        adv_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (adv_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/eth_pkt_gen.sv
// Packet-traffic sequencer driving the tx_start_en/tx_req/tx_done handshake
// of the ICMP/UDP Ethernet TX cores in the gmii_clk domain.
module eth_pkt_gen
    import eth_pkt_gen_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned PKT_COUNT      = 2,
    parameter int unsigned LEN_MIN        = 20,
    parameter int unsigned LEN_MAX        = 28,
    parameter int unsigned LEN_STEP       = 8,
    parameter int unsigned GAP_CYCLES     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned PATTERN        = 0,
    parameter logic [47:0] DES_MAC        = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP         = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic              gmii_clk,
    input  logic              sys_rst_n,
    input  logic              run,
    input  logic              stop,
    input  logic              tx_req,
    input  logic              tx_done,
    output logic              tx_start_en,
    output logic [15:0]       tx_byte_num,
    output logic [DATA_W-1:0] tx_data,
    output logic [47:0]       des_mac,
    output logic [31:0]       des_ip,
    output logic              busy,
    output logic [15:0]       pkt_cnt,
    output logic              timeout_err,
    output logic              run_done
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    gen_state_e       state_q, state_d;
    logic             run_q;
    logic             stop_q, stop_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      len_q, len_d;
    logic             to_err_q, to_err_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [47:0]      des_mac_q;
    logic [31:0]      des_ip_q;

    logic             run_rise;
    logic             data_load;
    logic             data_adv;
    logic [16:0]      len_sum;
    logic [15:0]      next_len;

    assign run_rise = run & ~run_q;
    assign len_sum  = {1'b0, len_q} + 17'(LEN_STEP);
    assign next_len = (len_sum > 17'(LEN_MAX)) ? 16'(LEN_MIN) : len_sum[15:0];

    always_comb begin
        state_d   = state_q;
        stop_d    = stop_q;
        pkt_cnt_d = pkt_cnt_q;
        len_d     = len_q;
        to_err_d  = to_err_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        data_load = 1'b0;
        data_adv  = 1'b0;

        if (state_q == ST_IDLE) begin
            stop_d = 1'b0;
        end else if (stop) begin
            stop_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (run_rise) begin
                    state_d   = ST_START;
                    pkt_cnt_d = '0;
                    to_err_d  = 1'b0;
                    len_d     = 16'(LEN_MIN);
                    data_load = 1'b1;
                end
            end
            ST_START: begin
                // The start-pulse cycle counts as the first supervised cycle.
                to_cnt_d = TO_W'(1);
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (pkt_cnt_q != 16'hFFFF) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end
                    data_load = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    data_adv = tx_req;
                    if (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1)) begin
                        to_err_d = 1'b1;
                        state_d  = ST_FINISH;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (stop_q || stop ||
                        (PKT_COUNT != 0 && pkt_cnt_q == 16'(PKT_COUNT))) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_START;
                        len_d   = next_len;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            stop_q    <= 1'b0;
            pkt_cnt_q <= '0;
            len_q     <= '0;
            to_err_q  <= 1'b0;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
            des_mac_q <= DES_MAC;
            des_ip_q  <= DES_IP;
        end else begin
            state_q   <= state_d;
            run_q     <= run;
            stop_q    <= stop_d;
            pkt_cnt_q <= pkt_cnt_d;
            len_q     <= len_d;
            to_err_q  <= to_err_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
            des_mac_q <= DES_MAC;
            des_ip_q  <= DES_IP;
        end
    end

    if (PATTERN == PATTERN_LFSR) begin : g_lfsr
        logic [31:0] lfsr_state;

        eth_pkt_gen_lfsr u_lfsr (
            .clk_i   (gmii_clk),
            .rst_ni  (sys_rst_n),
            .load_i  (data_load),
            .adv_i   (data_adv),
            .seed_i  (LFSR_SEED),
            .state_o (lfsr_state)
        );

        assign tx_data = lfsr_state[DATA_W-1:0];
    end else begin : g_inc
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;

        always_comb begin
            data_d = data_q;
            if (data_load) begin
                data_d = '0;
            end else if (data_adv) begin
                data_d = data_q + DATA_W'(1);
            end
        end

        always_ff @(posedge gmii_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign tx_data = data_q;
    end

    assign tx_start_en = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign run_done    = (state_q == ST_FINISH);
    assign tx_byte_num = len_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign timeout_err = to_err_q;
    assign des_mac     = des_mac_q;
    assign des_ip      = des_ip_q;

endmodule

// File: doc/eth_pkt_gen.md
Name: eth_pkt_gen

Overview:
- Synthesizable packet-traffic sequencer that drives the tx request/done handshake of the ICMP/UDP Ethernet TX cores.
- Replaces the hand-coded single-shot stimulus flow with a parametrised generator providing:
  - packet count, length sweep, inter-packet gap
  - data pattern mode
  - done-timeout supervision
- Sits in the gmii_clk domain between board control logic (or a bench) and the protocol TX module.

Parameters:
- DATA_W, 32, width of tx_data word (8, 16 or 32).
- PKT_COUNT, 2, packets per run; 0 = run until stop.
- LEN_MIN, 20, first tx_byte_num value.
- LEN_MAX, 28, upper bound of length sweep.
- LEN_STEP, 8, length increment per packet.
- GAP_CYCLES, 100, idle cycles between tx_done and next tx_start_en (minimum 1).
- TIMEOUT_CYCLES, 4096, max cycles from tx_start_en to tx_done.
- PATTERN, 0, 0 = incrementing word from 0, 1 = 32-bit LFSR.
- DES_MAC, 48'hff_ff_ff_ff_ff_ff, destination MAC driven to TX core.
- DES_IP, {8'd192,8'd168,8'd1,8'd10}, destination IP driven to TX core.

Ports:
- gmii_clk  in  1  clock.
- sys_rst_n  in  1  reset.
- run  in  1  level-pulse; rising edge starts a run when idle.
- stop  in  1  pulse; ends the run after the current packet.
- tx_req  in  1  TX core requests the next data word.
- tx_done  in  1  TX core finished the packet (1-cycle pulse).
- tx_start_en  out  1  1-cycle start pulse to TX core.
- tx_byte_num  out  16  payload length of the current packet.
- tx_data  out  DATA_W  payload word.
- des_mac  out  48  destination MAC.
- des_ip  out  32  destination IP.
- busy  out  1  run in progress.
- pkt_cnt  out  16  packets completed in the current run.
- timeout_err  out  1  sticky; tx_done missed.
- run_done  out  1  1-cycle pulse at end of run.

Behaviour:
- Reset and clocking:
  - Reset is sys_rst_n, asynchronous, active-low; clock is gmii_clk; all state on posedge gmii_clk.
  - Reset values: all outputs 0, except des_mac=DES_MAC and des_ip=DES_IP, which are registered constants.
- States: IDLE, START, WAIT_DONE, GAP, FINISH.
- IDLE:
  - Rising edge of run (registered edge detect) → START.
  - On entry to START: pkt_cnt=0, timeout_err=0, tx_byte_num=LEN_MIN, tx_data=seed.
- START:
  - tx_start_en=1 for exactly one cycle → WAIT_DONE.
  - Timeout counter cleared.
- WAIT_DONE:
  - Each cycle with tx_req=1: tx_data advances one step, visible the next cycle.
    - PATTERN 0: tx_data+1, wrapping modulo 2^DATA_W.
    - PATTERN 1: LFSR x^32+x^22+x^2+x+1, low DATA_W bits output.
  - tx_done=1:
    - pkt_cnt+1 (saturates at 16'hFFFF); tx_data reloads seed; → GAP.
    - tx_done wins over a same-cycle tx_req.
  - Timeout counter reaches TIMEOUT_CYCLES-1 without tx_done: timeout_err=1 (sticky until next run start); → FINISH.
- GAP:
  - Counts GAP_CYCLES.
  - At last gap cycle: if stop latched, or PKT_COUNT≠0 and pkt_cnt==PKT_COUNT → FINISH; else → START.
  - Next length: tx_byte_num+LEN_STEP; wraps to LEN_MIN if result > LEN_MAX. Computed in 17 bits to avoid overflow.
- FINISH: run_done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE.
- Seed: 0 for PATTERN 0; 32'hACE1_2468 for PATTERN 1, reloaded per packet so each packet is reproducible.
- stop:
  - Latched in any non-IDLE state; cleared in IDLE.
  - stop during WAIT_DONE never truncates the current packet.
- run edge while busy is ignored.
- Reset mid-packet returns to IDLE immediately; tx_start_en is never re-pulsed without a new run edge.

Decomposition:
- Package eth_pkt_gen_pkg contains:
  - state enum
  - PATTERN_INC/PATTERN_LFSR constants
  - LFSR polynomial tap mask
  - LFSR seed constant
- One sub-module, eth_pkt_gen_lfsr: Galois 32-bit LFSR with load/advance enables.

Test Plan:
- Loopback to the icmp core with defaults, run pulse → two tx_start_en pulses:
  - tx_byte_num 20 then 28
  - tx_data counts 0,1,2… per tx_req and restarts at 0 on the second packet
  - start pulses ≥100 cycles apart
  - run_done after pkt_cnt=2
- LEN_MIN=20, LEN_MAX=40, LEN_STEP=10, PKT_COUNT=5 → lengths 20,30,40,20,30.
- PATTERN=1, PKT_COUNT=2 → both packets carry an identical word sequence whose first word is 32'hACE1_2468.
- Stalled responder (tx_done never asserted), TIMEOUT_CYCLES=64:
  - timeout_err rises 64 cycles after tx_start_en
  - run_done pulses; busy falls
- PKT_COUNT=0 with stop mid-packet 3:
  - packet 3 completes
  - no further tx_start_en; pkt_cnt=3
- Same-cycle tx_req+tx_done → tx_data = seed next cycle; sys_rst_n low mid-WAIT_DONE → all outputs at reset values, no start pulse until a new run edge.
